impl_checker: RTL and testbench

IMPL_CHECKER -- requirements
Module: impl_checker

---
 rtl/impl_chk_pkg.sv | 28 ++
 rtl/impl_chk_lane.sv | 97 +++++++++
 rtl/impl_checker.sv | 61 ++++++
 tb/tb_impl_checker.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/impl_chk_pkg.sv
// Shared types and helpers for the implication checker.
package impl_chk_pkg;

  localparam int unsigned DLY_MIN   = 1;
  localparam int unsigned DLY_MAX   = 15;
  localparam int unsigned CNT_W_MIN = 1;
  localparam int unsigned CNT_W_MAX = 32;
  localparam int unsigned SUM_W     = CNT_W_MAX + 1;

  typedef enum logic {
    IMPL_OVL    = 1'b0,
    IMPL_NONOVL = 1'b1
  } impl_mode_e;

  // Add a small increment to a counter of width w, clamping at 2^w-1.
  function automatic logic [CNT_W_MAX-1:0] sat_add(
    input logic [CNT_W_MAX-1:0] cur,
    input logic [1:0]           inc,
    input int unsigned          w
  );
    logic [SUM_W-1:0] lim;
    logic [SUM_W-1:0] sum;
    lim = (SUM_W'(1) << w) - SUM_W'(1);
    sum = SUM_W'(cur) + SUM_W'(inc);
    return (sum > lim) ? CNT_W_MAX'(lim) : CNT_W_MAX'(sum);
  endfunction

endpackage

// File: rtl/impl_chk_lane.sv
// One checker channel: attempt pipeline, a/b evaluation, pulses, sticky flag
// and (with IMPL_CHK_CNT_EN defined) saturating pass/fail counters.
module impl_chk_lane
  import impl_chk_pkg::*;
#(
  parameter int unsigned DLY   = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  impl_mode_e       mode,
  input  logic             flush,
  input  logic             clr,
  input  logic             valid,
  input  logic             a,
  input  logic             b,
  output logic             pass_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_sticky
);

  logic           v_q;
  logic [DLY-1:0] pend_q;
  logic [DLY-1:0] pend_d;
  logic           start_req;
  logic           a_fail;
  logic           resolve;
  logic           b_pass;
  logic           b_fail;
  logic           fail_d;

  // Attempt start, a-sample, b-sample and pipeline advance for this cycle.
  always_comb begin
    start_req = 1'b0;
    if (!clr) begin
      // In non-overlapping mode the attempt was latched last cycle; a mode
      // change means that latched valid belongs to the old mode.
      start_req = (mode == IMPL_NONOVL) ? (v_q & ~flush) : valid;
    end
    a_fail  = start_req & ~a;
    resolve = pend_q[DLY-1] & ~flush & ~clr;
    b_pass  = resolve & b;
    b_fail  = resolve & ~b;
    fail_d  = a_fail | b_fail;
    if (flush || clr) begin
      pend_d = DLY'(start_req & a);
    end else begin
      pend_d = (pend_q << 1) | DLY'(start_req & a);
    end
  end

  // Pipeline, pulse and sticky registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q         <= 1'b0;
      pend_q      <= '0;
      pass_o      <= 1'b0;
      fail_o      <= 1'b0;
      fail_sticky <= 1'b0;
    end else begin
      v_q         <= valid & ~clr;
      pend_q      <= pend_d;
      pass_o      <= b_pass;
      fail_o      <= fail_d;
      fail_sticky <= clr ? 1'b0 : (fail_sticky | fail_d);
    end
  end

`ifdef IMPL_CHK_CNT_EN
  logic [1:0] pass_inc;
  logic [1:0] fail_inc;

  assign pass_inc = {1'b0, b_pass};
  // An a-fail and a b-fail may land together; both are counted.
  assign fail_inc = {1'b0, a_fail} + {1'b0, b_fail};

  // Saturating event counters, zeroed by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (clr) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      pass_cnt <= CNT_W'(sat_add(CNT_W_MAX'(pass_cnt), pass_inc, CNT_W));
      fail_cnt <= CNT_W'(sat_add(CNT_W_MAX'(fail_cnt), fail_inc, CNT_W));
    end
  end
`else
  assign pass_cnt = '0;
  assign fail_cnt = '0;
`endif

endmodule

// File: rtl/impl_checker.sv
// Multi-channel implication checker (valid |-> a ##DLY b).
// Optional counters enabled by defining IMPL_CHK_CNT_EN.
module impl_checker
  import impl_chk_pkg::*;
#(
  parameter int unsigned CH    = 4,
  parameter int unsigned DLY   = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       valid,
  input  logic [CH-1:0]       a,
  input  logic [CH-1:0]       b,
  input  logic                nonovl,
  input  logic                clr,
  output logic [CH-1:0]       pass_o,
  output logic [CH-1:0]       fail_o,
  output logic [CH*CNT_W-1:0] pass_cnt,
  output logic [CH*CNT_W-1:0] fail_cnt,
  output logic [CH-1:0]       fail_sticky
);

  logic       nonovl_q;
  logic       mode_chg;
  impl_mode_e mode;

  assign mode     = impl_mode_e'(nonovl);
  assign mode_chg = nonovl ^ nonovl_q;

  // Previous-cycle mode, used to detect a mode switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nonovl_q <= 1'b0;
    end else begin
      nonovl_q <= nonovl;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_lane
    impl_chk_lane #(
      .DLY   (DLY),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .mode        (mode),
      .flush       (mode_chg),
      .clr         (clr),
      .valid       (valid[i]),
      .a           (a[i]),
      .b           (b[i]),
      .pass_o      (pass_o[i]),
      .fail_o      (fail_o[i]),
      .pass_cnt    (pass_cnt[i*CNT_W +: CNT_W]),
      .fail_cnt    (fail_cnt[i*CNT_W +: CNT_W]),
      .fail_sticky (fail_sticky[i])
    );
  end

endmodule

// File: tb/tb_impl_checker.sv
// Directed bench for impl_checker (CH=4, DLY=3, 4-bit counters).
module tb_impl_checker;

  localparam int unsigned CH  = 4;
  localparam int unsigned DLY = 3;
  localparam int unsigned CW  = 4;
`ifdef IMPL_CHK_CNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [CH-1:0]   valid;
  logic [CH-1:0]   a;
  logic [CH-1:0]   b;
  logic            nonovl;
  logic            clr;
  logic [CH-1:0]   pass_o;
  logic [CH-1:0]   fail_o;
  logic [CH*CW-1:0] pass_cnt;
  logic [CH*CW-1:0] fail_cnt;
  logic [CH-1:0]   fail_sticky;

  int checks = 0;
  int errors = 0;

  impl_checker #(.CH(CH), .DLY(DLY), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (valid),
    .a           (a),
    .b           (b),
    .nonovl      (nonovl),
    .clr         (clr),
    .pass_o      (pass_o),
    .fail_o      (fail_o),
    .pass_cnt    (pass_cnt),
    .fail_cnt    (fail_cnt),
    .fail_sticky (fail_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counter value: counters read as zero when compiled out.
  function automatic logic [CW-1:0] ec(input int v);
    return CE ? CW'(v) : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    valid = '0; a = '0; b = '0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; valid = '0; a = '0; b = '0; nonovl = 1'b0; clr = 1'b0;
    #2 rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({pass_o, fail_o} !== '0) begin
      errors++; $display("FAIL reset_pulses got %b/%b want 0/0", pass_o, fail_o);
    end
    checks++;
    if ({pass_cnt, fail_cnt} !== '0) begin
      errors++; $display("FAIL reset_cnt got %h/%h want 0/0", pass_cnt, fail_cnt);
    end
    checks++;
    if (fail_sticky !== '0) begin
      errors++; $display("FAIL reset_sticky got %b want 0", fail_sticky);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ovl_pass();
    do_clr();
    valid = 4'b0011; a = 4'b0001; b = '0;
    checks++;
    if ({pass_o, fail_o} !== '0) begin
      errors++; $display("FAIL clr_suppress got %b/%b want 0/0", pass_o, fail_o);
    end
    tick();
    valid = '0; a = '0;
    checks++;
    if (fail_o !== 4'b0010 || pass_o !== 4'b0000) begin
      errors++; $display("FAIL ovl_ch1_afail got fail=%b pass=%b want 0010/0000", fail_o, pass_o);
    end
    tick(); tick();
    b = 4'b0001;
    checks++;
    if (pass_o !== 4'b0000) begin
      errors++; $display("FAIL ovl_early got pass=%b want 0000", pass_o);
    end
    tick();
    b = '0;
    checks++;
    if (pass_o !== 4'b0001 || fail_o !== 4'b0000) begin
      errors++; $display("FAIL ovl_pass got pass=%b fail=%b want 0001/0000", pass_o, fail_o);
    end
    checks++;
    if (pass_cnt[CW-1:0] !== ec(1) || fail_cnt[2*CW-1:CW] !== ec(1)) begin
      errors++; $display("FAIL ovl_cnt got p0=%0d f1=%0d want %0d/%0d",
                         pass_cnt[CW-1:0], fail_cnt[2*CW-1:CW], ec(1), ec(1));
    end
    checks++;
    if (fail_sticky !== 4'b0010) begin
      errors++; $display("FAIL ovl_sticky got %b want 0010", fail_sticky);
    end
  endtask

  task automatic test_a_fail();
    do_clr();
    checks++;
    if (fail_sticky !== '0 || fail_cnt !== '0 || pass_cnt !== '0) begin
      errors++; $display("FAIL clr_zero got sticky=%b fc=%h pc=%h want 0", fail_sticky, fail_cnt, pass_cnt);
    end
    valid = 4'b0001; a = '0;
    tick();
    valid = '0;
    checks++;
    if (fail_o !== 4'b0001 || fail_sticky !== 4'b0001 || fail_cnt[CW-1:0] !== ec(1)) begin
      errors++; $display("FAIL a_fail got fail=%b sticky=%b cnt=%0d want 0001/0001/%0d",
                         fail_o, fail_sticky, fail_cnt[CW-1:0], ec(1));
    end
    tick();
    checks++;
    if (fail_o !== 4'b0000 || fail_sticky !== 4'b0001) begin
      errors++; $display("FAIL a_fail_hold got fail=%b sticky=%b want 0000/0001", fail_o, fail_sticky);
    end
  endtask

  task automatic test_nonovl();
    do_clr();
    nonovl = 1'b1;
    tick(); tick();
    valid = 4'b0001; a = '0; b = '0;
    tick();
    valid = '0; a = 4'b0001;
    checks++;
    if (fail_o !== 4'b0000) begin
      errors++; $display("FAIL nonovl_no_t0_sample got fail=%b want 0000", fail_o);
    end
    tick();
    a = '0;
    tick(); tick();
    b = 4'b0001;
    tick();
    b = '0;
    checks++;
    if (pass_o !== 4'b0001 || fail_o !== 4'b0000) begin
      errors++; $display("FAIL nonovl_pass got pass=%b fail=%b want 0001/0000", pass_o, fail_o);
    end
    nonovl = 1'b0;
    tick(); tick();
    valid = 4'b0001; a = 4'b0001; b = '0;
    tick();
    valid = '0;
    tick();
    a = '0;
    tick();
    checks++;
    if (fail_o !== 4'b0000) begin
      errors++; $display("FAIL ovl_same_early got fail=%b want 0000", fail_o);
    end
    tick();
    b = 4'b0001;
    checks++;
    if (fail_o !== 4'b0001 || pass_o !== 4'b0000) begin
      errors++; $display("FAIL ovl_same_fail got fail=%b pass=%b want 0001/0000", fail_o, pass_o);
    end
    tick();
    b = '0;
    checks++;
    if (pass_o !== 4'b0000) begin
      errors++; $display("FAIL ovl_same_late got pass=%b want 0000", pass_o);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_p;
    logic exp_f;
    do_clr();
    for (int c = 0; c < 15; c++) begin
      valid[0] = (c < 10);
      a[0]     = (c < 10);
      b[0]     = (c != 7) && (c < 13);
      exp_p    = (c >= 4) && (c <= 13) && (c != 8);
      exp_f    = (c == 8);
      checks++;
      if (pass_o[0] !== exp_p || fail_o[0] !== exp_f) begin
        errors++; $display("FAIL b2b cycle %0d got pass=%b fail=%b want %b/%b",
                           c, pass_o[0], fail_o[0], exp_p, exp_f);
      end
      tick();
    end
    checks++;
    if (pass_cnt[CW-1:0] !== ec(9) || fail_cnt[CW-1:0] !== ec(1)) begin
      errors++; $display("FAIL b2b_cnt got %0d/%0d want %0d/%0d",
                         pass_cnt[CW-1:0], fail_cnt[CW-1:0], ec(9), ec(1));
    end
  endtask

  task automatic test_coincide();
    do_clr();
    valid = 4'b0001; a = 4'b0001; b = '0;
    tick();
    valid = '0; a = '0;
    tick(); tick();
    valid = 4'b0001; a = '0;
    tick();
    checks++;
    if (fail_o !== 4'b0001 || pass_o !== 4'b0000 || fail_cnt[CW-1:0] !== ec(2)) begin
      errors++; $display("FAIL dual_fail got fail=%b pass=%b cnt=%0d want 0001/0000/%0d",
                         fail_o, pass_o, fail_cnt[CW-1:0], ec(2));
    end
    valid = 4'b0001; a = 4'b0001; b = '0;
    tick();
    valid = '0; a = '0;
    tick(); tick();
    valid = 4'b0001; a = '0; b = 4'b0001;
    tick();
    valid = '0; b = '0;
    checks++;
    if (pass_o !== 4'b0001 || fail_o !== 4'b0001) begin
      errors++; $display("FAIL pass_and_fail got pass=%b fail=%b want 0001/0001", pass_o, fail_o);
    end
    checks++;
    if (pass_cnt[CW-1:0] !== ec(1) || fail_cnt[CW-1:0] !== ec(3)) begin
      errors++; $display("FAIL pass_and_fail_cnt got %0d/%0d want %0d/%0d",
                         pass_cnt[CW-1:0], fail_cnt[CW-1:0], ec(1), ec(3));
    end
  endtask

  task automatic test_saturate();
    do_clr();
    valid = 4'b0001; a = 4'b0001; b = 4'b0001;
    repeat (20) tick();
    valid = '0; a = '0;
    repeat (5) tick();
    checks++;
    if (pass_cnt[CW-1:0] !== ec(15)) begin
      errors++; $display("FAIL pass_sat got %0d want %0d", pass_cnt[CW-1:0], ec(15));
    end
    valid = 4'b0001; a = 4'b0001;
    tick();
    valid = '0; a = '0;
    tick(); tick(); tick();
    checks++;
    if (pass_o !== 4'b0001 || pass_cnt[CW-1:0] !== ec(15)) begin
      errors++; $display("FAIL pass_sat_hold got pass=%b cnt=%0d want 0001/%0d",
                         pass_o, pass_cnt[CW-1:0], ec(15));
    end
    b = '0;
    valid = 4'b0001; a = '0;
    repeat (14) tick();
    valid = '0;
    tick();
    checks++;
    if (fail_cnt[CW-1:0] !== ec(14)) begin
      errors++; $display("FAIL fail_pre_sat got %0d want %0d", fail_cnt[CW-1:0], ec(14));
    end
    valid = 4'b0001; a = 4'b0001;
    tick();
    valid = '0; a = '0;
    tick(); tick();
    valid = 4'b0001;
    tick();
    valid = '0;
    checks++;
    if (fail_o !== 4'b0001 || fail_cnt[CW-1:0] !== ec(15)) begin
      errors++; $display("FAIL fail_sat got fail=%b cnt=%0d want 0001/%0d",
                         fail_o, fail_cnt[CW-1:0], ec(15));
    end
  endtask

  task automatic test_flush_reset();
    do_clr();
    for (int c = 0; c < 5; c++) begin
      valid[0] = (c != 1);
      a[0]     = (c != 1);
      b[0]     = 1'b1;
      tick();
    end
    // now in cycle 5: attempts from cycles 2,3,4 pending
    checks++;
    if (pass_cnt[CW-1:0] !== ec(1)) begin
      errors++; $display("FAIL pre_reset_cnt got %0d want %0d", pass_cnt[CW-1:0], ec(1));
    end
    valid = '0; a = '0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pass_o !== '0 || pass_cnt !== '0) begin
      errors++; $display("FAIL reset_immediate got pass=%b cnt=%h want 0/0", pass_o, pass_cnt);
    end
    tick();
    rst_n = 1'b1;
    valid = 4'b0001; a = 4'b0001;
    for (int c = 6; c < 11; c++) begin
      checks++;
      if (pass_o !== ((c == 10) ? 4'b0001 : 4'b0000) || fail_o !== 4'b0000) begin
        errors++; $display("FAIL post_reset cycle %0d got pass=%b fail=%b", c, pass_o, fail_o);
      end
      tick();
      valid = '0; a = '0;
    end
    b = '0;
  endtask

  task automatic test_flush_toggle();
    do_clr();
    for (int c = 0; c < 5; c++) begin
      valid[0] = (c != 1);
      a[0]     = (c != 1);
      b[0]     = (c < 4);
      tick();
    end
    valid = '0; a = '0; b = '0;
    nonovl = 1'b1;
    for (int c = 5; c < 11; c++) begin
      checks++;
      if (pass_o !== 4'b0000 || fail_o !== 4'b0000) begin
        errors++; $display("FAIL toggle_pulse cycle %0d got pass=%b fail=%b want 0/0", c, pass_o, fail_o);
      end
      tick();
    end
    checks++;
    if (pass_cnt[CW-1:0] !== ec(1) || fail_cnt[CW-1:0] !== ec(0)) begin
      errors++; $display("FAIL toggle_cnt got %0d/%0d want %0d/%0d",
                         pass_cnt[CW-1:0], fail_cnt[CW-1:0], ec(1), ec(0));
    end
    nonovl = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_ovl_pass();
    test_a_fail();
    test_nonovl();
    test_back_to_back();
    test_coincide();
    test_saturate();
    test_flush_reset();
    test_flush_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
